// File: rtl/pio_irq_master_pkg.sv
// Shared FSM state encoding and PIO register map for the PIO interrupt master.
package pio_irq_master_pkg;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_EDGE,
    ST_WT_EDGE,
    ST_CLR,
    ST_RD_LVL,
    ST_WT_LVL,
    ST_PUSH,
    ST_MASK
  } state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/pio_irq_master.sv
// Services a PIO slave's edge-capture interrupt over Avalon-MM and turns each
// nonzero capture into a ready/valid button event with the pin levels read afterwards.
module pio_irq_master
  import pio_irq_master_pkg::*;
#(
  parameter int               PIO_W     = 2,
  parameter logic [PIO_W-1:0] INIT_MASK = 2'b11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  output logic [1:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  input  logic             mask_wr,
  input  logic [PIO_W-1:0] mask_in,
  output logic             evt_valid,
  output logic [PIO_W-1:0] evt_edges,
  output logic [PIO_W-1:0] evt_level,
  input  logic             evt_ready,
  output logic [7:0]       evt_count
);

  state_e           state_q, state_d;
  logic [1:0]       address_q, address_d;
  logic             chipselect_q, chipselect_d;
  logic             write_n_q, write_n_d;
  logic [31:0]      writedata_q, writedata_d;
  logic             evt_valid_q, evt_valid_d;
  logic [PIO_W-1:0] edges_q, edges_d;
  logic [PIO_W-1:0] level_q, level_d;
  logic [7:0]       count_q, count_d;
  logic             skip_q, skip_d;
  logic             pend_q, pend_d;
  logic [PIO_W-1:0] pend_mask_q, pend_mask_d;

  logic unused_rd_bits;
  assign unused_rd_bits = ^readdata[31:PIO_W];

  // Bus outputs are registered: the values chosen on a transition are what the
  // slave sees for the whole cycle spent in the destination state.
  always_comb begin
    state_d      = state_q;
    address_d    = ADDR_DATA;
    chipselect_d = 1'b0;
    write_n_d    = 1'b1;
    writedata_d  = '0;
    evt_valid_d  = evt_valid_q;
    edges_d      = edges_q;
    level_d      = level_q;
    count_d      = count_q;
    skip_d       = skip_q;
    pend_d       = pend_q;
    pend_mask_d  = pend_mask_q;

    if (mask_wr && (state_q != ST_IDLE)) begin
      pend_d      = 1'b1;
      pend_mask_d = mask_in;
    end

    case (state_q)
      ST_INIT: begin
        // First INIT cycle after reset raises the mask write; the second moves on.
        if (write_n_q) begin
          chipselect_d = 1'b1;
          write_n_d    = 1'b0;
          address_d    = ADDR_MASK;
          writedata_d  = 32'(INIT_MASK);
        end else begin
          state_d      = ST_CLR;
          skip_d       = 1'b1;
          chipselect_d = 1'b1;
          write_n_d    = 1'b0;
          address_d    = ADDR_EDGE;
        end
      end
      ST_IDLE: begin
        if (mask_wr || pend_q) begin
          state_d      = ST_MASK;
          pend_d       = 1'b0;
          chipselect_d = 1'b1;
          write_n_d    = 1'b0;
          address_d    = ADDR_MASK;
          writedata_d  = mask_wr ? 32'(mask_in) : 32'(pend_mask_q);
        end else if (irq) begin
          state_d      = ST_RD_EDGE;
          chipselect_d = 1'b1;
          address_d    = ADDR_EDGE;
        end
      end
      ST_MASK: begin
        state_d = ST_IDLE;
      end
      ST_RD_EDGE: begin
        state_d = ST_WT_EDGE;
      end
      ST_WT_EDGE: begin
        edges_d      = readdata[PIO_W-1:0];
        state_d      = ST_CLR;
        chipselect_d = 1'b1;
        write_n_d    = 1'b0;
        address_d    = ADDR_EDGE;
      end
      ST_CLR: begin
        if (skip_q) begin
          skip_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (edges_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d      = ST_RD_LVL;
          chipselect_d = 1'b1;
          address_d    = ADDR_DATA;
        end
      end
      ST_RD_LVL: begin
        state_d = ST_WT_LVL;
      end
      ST_WT_LVL: begin
        level_d     = readdata[PIO_W-1:0];
        evt_valid_d = 1'b1;
        state_d     = ST_PUSH;
      end
      ST_PUSH: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          count_d     = count_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      address_q    <= ADDR_DATA;
      chipselect_q <= 1'b0;
      write_n_q    <= 1'b1;
      writedata_q  <= '0;
      evt_valid_q  <= 1'b0;
      edges_q      <= '0;
      level_q      <= '0;
      count_q      <= '0;
      skip_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      chipselect_q <= chipselect_d;
      write_n_q    <= write_n_d;
      writedata_q  <= writedata_d;
      evt_valid_q  <= evt_valid_d;
      edges_q      <= edges_d;
      level_q      <= level_d;
      count_q      <= count_d;
      skip_q       <= skip_d;
      pend_q       <= pend_d;
      pend_mask_q  <= pend_mask_d;
    end
  end

  assign address    = address_q;
  assign chipselect = chipselect_q;
  assign write_n    = write_n_q;
  assign writedata  = writedata_q;
  assign evt_valid  = evt_valid_q;
  assign evt_edges  = edges_q;
  assign evt_level  = level_q;
  assign evt_count  = count_q;

endmodule
